alu_issue_wb: RTL
=================

# alu_issue_wb

Two-stage issue/writeback controller that wraps the combinational `alu`. It accepts one instruction per cycle over a valid/ready handshake and reads operands from an internal register file. It drives the ALU inputs, registers the ALU result and flags, and writes them back one cycle later. It sits directly upstream of the `alu` (driving `in_a`/`in_b`/`opcode`) and consumes its `out`/`flags`.

## Interface
- `BW`, 16, datapath width; must match the `alu` instance.
- `NREG`, 8, number of registers; register index width is `$clog2(NREG)` (3 at default).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr_valid`  in  1  instruction present.
- `instr_ready`  out  1  instruction accepted this cycle when high together with `instr_valid`.
- `instr_opcode`  in  3  ALU opcode (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 INC, 110 MOVA, 111 MOVB).
- `instr_rd`, `instr_ra`, `instr_rb`  in  3  destination and source register indices.
- `instr_imm_sel`  in  1  1: operand B is `instr_imm`; 0: operand B is R[rb].
- `instr_imm`  in  BW  signed immediate.
- `alu_a`, `alu_b`  out  BW  to `alu.in_a`/`alu.in_b`.
- `alu_opcode`  out  3  to `alu.opcode`; equals `instr_opcode`.
- `alu_out`  in  BW  from `alu.out`.
- `alu_flags`  in  3  from `alu.flags`, {overflow, negative, zero}.
- `wb_valid`  out  1  writeback stage occupied.
- `wb_rd`  out  3  writeback destination.
- `wb_data`  out  BW  writeback value.
- `flags`  out  3  architectural flag register {overflow, negative, zero}.
- `dbg_addr`  in  3  debug read index.
- `dbg_data`  out  BW  R[dbg_addr], combinational.

## Operation
- Register file: NREG x BW flops. R0 reads as 0 always; writes to R0 are discarded. Flags still update on an R0 write.
- Stage 1 (issue, combinational):
  - `alu_a` = R[ra] after bypass.
  - `alu_b` = `instr_imm_sel` ? `instr_imm` : R[rb] after bypass.
- Accept: on a rising edge with `instr_valid && instr_ready`:
  - `wb_valid`<=1, `wb_rd`<=`instr_rd`, `wb_data`<=`alu_out`, internal `wb_flags`<=`alu_flags`.
- No accept on an edge: `wb_valid`<=0; the other stage-2 registers hold.
- Stage 2 (writeback): on a rising edge with `wb_valid`=1:
  - R[wb_rd]<=`wb_data` (skipped if `wb_rd`=0).
  - `flags`<=`wb_flags`.
- Hazard: `wb_valid`=1, `wb_rd`!=0, and (`wb_rd`==`instr_ra`, or (`instr_imm_sel`=0 and `wb_rd`==`instr_rb`)). Check is conservative: independent of opcode.
- Hazard handling is set by configuration; see ## Configuration.
- Arithmetic is entirely inside `alu`; this block never modifies `alu_out` or `alu_flags`.

## Timing
- Reset values, asserted asynchronously while `rst`=1:
  - All registers 0, `flags`=000, `wb_valid`=0, `wb_rd`=0, `wb_data`=0.
  - `instr_ready`=0 while `rst` is high.
- Latency: instruction accepted at edge N.
  - `wb_valid`/`wb_data` visible after edge N.
  - R[rd] and `flags` updated at edge N+1.
  - `dbg_data` reflects the write after edge N+1.
- Throughput: one instruction per cycle with bypass. One bubble per hazard without it.
- `instr_ready` is combinational from `rst`, stage-2 state and instruction fields. It does not depend on `instr_valid`.
- Upstream must hold instruction fields stable while `instr_valid`=1 and `instr_ready`=0.
- Simultaneous write and debug read of the same register: `dbg_data` shows the old value until the edge.
- Reset asserted with `wb_valid`=1: the pending writeback is dropped; the register file is cleared.

## Configuration
- Macro: `ALU_BYPASS_EN`.
- Defined: a hazarding operand is taken from `wb_data` instead of the register file. `instr_ready` = !`rst`.
- Undefined: no forwarding. `instr_ready` = !`rst` && !hazard, which inserts exactly one stall cycle per hazard.

## Test plan
- Reset: assert `rst` mid-stream with `wb_valid`=1 -> `wb_valid`=0, `flags`=000, `dbg_data`=0 for all indices, `instr_ready`=0 until release.
- Immediate load: MOVB R1 imm 5, then MOVB R2 imm 3 -> after two writebacks, R1=5, R2=3, `flags`=000.
- Back-to-back dependency: then ADD R3=R1+R2 issued the cycle after the R2 load:
  - With bypass: no stall, R3=8.
  - Without bypass: `instr_ready` low exactly one cycle, R3=8.
- Overflow: MOVB R1 imm 0x7FFF; INC R4=R1 -> R4=0x8000, `flags`=110.
- Zero: SUB R5=R1-R1 -> R5=0, `flags`=001.
- R0 write: MOVB R0 imm 9 -> `dbg_data`(R0)=0, `flags`=000. A following ADD R6=R0+imm 1 -> R6=1, with no stall in either configuration.

Source files
------------

// File: rtl/alu_issue_wb.sv
// alu_issue_wb: two-stage issue/writeback controller wrapped around a combinational alu.
// Define ALU_BYPASS_EN to forward the writeback value to hazarding operands instead of stalling.
module alu_issue_wb #(
  parameter int BW   = 16,
  parameter int NREG = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [2:0]              instr_opcode,
  input  logic [$clog2(NREG)-1:0] instr_rd,
  input  logic [$clog2(NREG)-1:0] instr_ra,
  input  logic [$clog2(NREG)-1:0] instr_rb,
  input  logic                    instr_imm_sel,
  input  logic [BW-1:0]           instr_imm,
  output logic [BW-1:0]           alu_a,
  output logic [BW-1:0]           alu_b,
  output logic [2:0]              alu_opcode,
  input  logic [BW-1:0]           alu_out,
  input  logic [2:0]              alu_flags,
  output logic                    wb_valid,
  output logic [$clog2(NREG)-1:0] wb_rd,
  output logic [BW-1:0]           wb_data,
  output logic [2:0]              flags,
  input  logic [$clog2(NREG)-1:0] dbg_addr,
  output logic [BW-1:0]           dbg_data
);

  localparam int RW = $clog2(NREG);

  // Entry 0 is cleared by reset and never written, so it always reads as zero.
  logic [BW-1:0] rf_q [NREG];

  logic          wb_valid_q, wb_valid_d;
  logic [RW-1:0] wb_rd_q, wb_rd_d;
  logic [BW-1:0] wb_data_q, wb_data_d;
  logic [2:0]    wb_flags_q, wb_flags_d;
  logic [2:0]    flags_q, flags_d;

  logic [BW-1:0] ra_val, rb_val;
  logic          hazard_a, hazard_b;
  logic          accept;
  logic          wb_write;

  always_comb begin
    ra_val   = rf_q[instr_ra];
    rb_val   = rf_q[instr_rb];
    hazard_a = wb_valid_q && (wb_rd_q != '0) && (wb_rd_q == instr_ra);
    hazard_b = wb_valid_q && (wb_rd_q != '0) && !instr_imm_sel && (wb_rd_q == instr_rb);
  end

`ifdef ALU_BYPASS_EN
  assign instr_ready = !rst;
  assign alu_a       = hazard_a ? wb_data_q : ra_val;
  assign alu_b       = instr_imm_sel ? instr_imm : (hazard_b ? wb_data_q : rb_val);
`else
  // Without forwarding the stale operand must not reach the alu, so hold off one cycle.
  assign instr_ready = !rst && !(hazard_a || hazard_b);
  assign alu_a       = ra_val;
  assign alu_b       = instr_imm_sel ? instr_imm : rb_val;
`endif

  assign alu_opcode = instr_opcode;
  assign accept     = instr_valid && instr_ready;
  assign wb_write   = wb_valid_q && (wb_rd_q != '0);

  always_comb begin
    wb_valid_d = accept;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_flags_d = wb_flags_q;
    flags_d    = flags_q;
    if (accept) begin
      wb_rd_d    = instr_rd;
      wb_data_d  = alu_out;
      wb_flags_d = alu_flags;
    end
    if (wb_valid_q) begin
      flags_d = wb_flags_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_flags_q <= '0;
      flags_q    <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_flags_q <= wb_flags_d;
      flags_q    <= flags_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_write) begin
      rf_q[wb_rd_q] <= wb_data_q;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign flags    = flags_q;
  assign dbg_data = rf_q[dbg_addr];

endmodule
